// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared FSM state type and ratio/phase helpers for multi_clkdiv_gen
package clkdiv_pkg;
    typedef enum logic [1:0] {HOLD, SETTLE, RUN, UPDATE} state_e;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic logic [31:0] half_up(input logic [31:0] div);
        return (div + 32'd1) >> 1;
    endfunction
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction
    function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] div);
        return (phase >= div) ? div - 32'd1 : phase;
    endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider counter with ratio/phase registers and registered clock/strobe
module clkdiv_channel import clkdiv_pkg::*; #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clear,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic [DIV_W-1:0] load_phase,
    output logic             wrap,
    output logic             outclk,
    output logic             strobe
);
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, phase_q, phase_d;
    logic             outclk_q, outclk_d, strobe_q, strobe_d;

    assign wrap   = cnt_q == div_q - DIV_W'(1);
    assign outclk = outclk_q;
    assign strobe = strobe_q;

    // outputs come from the next counter value so they line up with cnt in the same cycle
    always_comb begin
        div_d    = load ? load_div : div_q;
        phase_d  = load ? load_phase : phase_q;
        cnt_d    = (clear || wrap) ? '0 : cnt_q + DIV_W'(1);
        outclk_d = run && (32'(cnt_d) < half_up(32'(div_d)));
        strobe_d = run && (cnt_d == phase_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            phase_q  <= '0;
            outclk_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            outclk_q <= outclk_d;
            strobe_q <= strobe_d;
        end
    end
endmodule

// File: rtl/multi_clkdiv_gen.sv
// multi_clkdiv_gen: lock-qualified multi-channel clock divider with glitch-free run-time reprogramming
module multi_clkdiv_gen import clkdiv_pkg::*; #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 21,
    parameter int SETTLE_CYC  = 256
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    lock_in,
    input  logic                    sync,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [DIV_W-1:0]        cfg_phase,
    output logic [NUM_CH-1:0]       outclk,
    output logic [NUM_CH-1:0]       strobe,
    output logic                    locked
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_e           state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CH_W-1:0]  sh_ch_q, sh_ch_d;
    logic [DIV_W-1:0] sh_div_q, sh_div_d, sh_phase_q, sh_phase_d;
    logic [DIV_W-1:0] new_div, new_phase, ld_div, ld_phase;
    logic [31:0]      nd;
    logic             hold_acc, accept, sync_run, apply, run_en, clear;
    logic [NUM_CH-1:0] wrap, tgt, load;

    assign cfg_ready = state_q == HOLD || state_q == RUN;
    assign locked    = state_q == RUN || state_q == UPDATE;

    always_comb begin
        nd         = clamp_div(32'(cfg_div));
        new_div    = DIV_W'(nd);
        new_phase  = DIV_W'(clamp_phase(32'(cfg_phase), nd));
        hold_acc   = state_q == HOLD && cfg_valid;
        accept     = state_q == RUN && cfg_valid;
        sync_run   = sync && (state_q == RUN || state_q == UPDATE);
        apply      = state_q == UPDATE && lock_in && (sync || |(wrap & tgt));
        state_d    = state_q;
        settle_d   = '0;
        sh_ch_d    = sh_ch_q;
        sh_div_d   = sh_div_q;
        sh_phase_d = sh_phase_q;
        if (!lock_in) state_d = HOLD;
        else case (state_q)
            HOLD:   state_d = SETTLE;
            SETTLE: begin
                state_d  = (settle_q == SET_W'(SETTLE_CYC - 1)) ? RUN : SETTLE;
                settle_d = settle_q + SET_W'(1);
            end
            RUN: if (accept) begin
                sh_ch_d    = cfg_ch;
                sh_div_d   = new_div;
                sh_phase_d = new_phase;
                state_d    = UPDATE;
            end
            UPDATE: state_d = (32'(sh_ch_q) >= NUM_CH || apply) ? RUN : UPDATE;
        endcase
        run_en   = state_d != HOLD;
        clear    = state_q == HOLD || !lock_in || sync_run;
        ld_div   = state_q == HOLD ? new_div : sh_div_q;
        ld_phase = state_q == HOLD ? new_phase : sh_phase_q;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= HOLD;
            settle_q   <= '0;
            sh_ch_q    <= '0;
            sh_div_q   <= '0;
            sh_phase_q <= '0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            sh_ch_q    <= sh_ch_d;
            sh_div_q   <= sh_div_d;
            sh_phase_q <= sh_phase_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign tgt[i]  = sh_ch_q == CH_W'(i);
        assign load[i] = (hold_acc && cfg_ch == CH_W'(i)) || (apply && tgt[i]);
        clkdiv_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
            .clk(refclk), .rst(rst), .run(run_en), .clear(clear), .load(load[i]),
            .load_div(ld_div), .load_phase(ld_phase), .wrap(wrap[i]),
            .outclk(outclk[i]), .strobe(strobe[i])
        );
    end
endmodule

// File: tb/tb_multi_clkdiv_gen.sv
// tb_multi_clkdiv_gen: directed and random stimulus checked against a timestamp-based divider model
module tb_multi_clkdiv_gen;
    localparam int NUM_CH = 5;
    localparam int DIV_W  = 16;
    localparam int DEF    = 21;
    localparam int SETTLE = 256;
    localparam int M_HOLD = 0, M_SETTLE = 1, M_RUN = 2, M_UPDATE = 3;

    logic refclk = 1'b0;
    logic rst, lock_in, sync, cfg_valid, cfg_ready, locked;
    logic [2:0] cfg_ch;
    logic [DIV_W-1:0] cfg_div, cfg_phase;
    logic [NUM_CH-1:0] outclk, strobe, eo, es;
    int n_checks = 0, n_errors = 0;
    int t = 0, st = M_HOLD, settle_end = 0, pch = 0, pdiv = 0, pph = 0;
    int mdiv [NUM_CH] = '{default: DEF};
    int mph [NUM_CH] = '{default: 0};
    int mstart [NUM_CH] = '{default: 0};

    always #5 refclk = ~refclk;

    multi_clkdiv_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEF), .SETTLE_CYC(SETTLE)) dut (
        .refclk(refclk), .rst(rst), .lock_in(lock_in), .sync(sync), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .outclk(outclk), .strobe(strobe), .locked(locked)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, t, got, exp);
        end
    endtask

    // model: each channel's count is elapsed cycles since its current period alignment, modulo div
    function automatic int mcnt(input int i);
        return (t - mstart[i]) % mdiv[i];
    endfunction

    always @(posedge refclk) begin : model
        int tn, d, p, c;
        tn = t + 1;
        if (rst) begin
            st = M_HOLD;
            for (int i = 0; i < NUM_CH; i++) begin
                mdiv[i] = DEF;
                mph[i] = 0;
            end
        end else begin
            d = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            p = (int'(cfg_phase) >= d) ? d - 1 : int'(cfg_phase);
            c = int'(cfg_ch);
            if (st == M_HOLD && cfg_valid && c < NUM_CH) begin
                mdiv[c] = d;
                mph[c] = p;
            end
            if (!lock_in) st = M_HOLD;
            else if (st == M_HOLD) begin
                st = M_SETTLE;
                settle_end = tn + SETTLE;
                for (int i = 0; i < NUM_CH; i++) mstart[i] = tn;
            end else if (st == M_SETTLE) begin
                if (tn == settle_end) st = M_RUN;
            end else if (st == M_RUN) begin
                if (sync) for (int i = 0; i < NUM_CH; i++) mstart[i] = tn;
                if (cfg_valid) begin
                    pch = c; pdiv = d; pph = p;
                    st = M_UPDATE;
                end
            end else begin
                if (pch < NUM_CH && (sync || mcnt(pch) == mdiv[pch] - 1)) begin
                    mdiv[pch] = pdiv;
                    mph[pch] = pph;
                    mstart[pch] = tn;
                    st = M_RUN;
                end
                if (sync) begin
                    for (int i = 0; i < NUM_CH; i++) mstart[i] = tn;
                    st = M_RUN;
                end
                if (pch >= NUM_CH) st = M_RUN;
            end
        end
        t = tn;
    end

    always @(negedge refclk) begin
        if (t > 0) begin
            eo = '0;
            es = '0;
            if (st != M_HOLD)
                for (int i = 0; i < NUM_CH; i++) begin
                    eo[i] = mcnt(i) < (mdiv[i] + 1) / 2;
                    es[i] = mcnt(i) == mph[i];
                end
            chk("outclk", 64'(outclk), 64'(eo));
            chk("strobe", 64'(strobe), 64'(es));
            chk("locked", 64'(locked), 64'(st == M_RUN || st == M_UPDATE));
            chk("cfg_ready", 64'(cfg_ready), 64'(st == M_HOLD || st == M_RUN));
        end
    end

    task automatic send_cfg(input int ch, input int d, input int p);
        int n = 0;
        while (!cfg_ready && n < 200) begin
            @(negedge refclk);
            n++;
        end
        if (!cfg_ready) chk("cfg_ready_timeout", 64'(cfg_ready), 64'(1));
        cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_div = DIV_W'(d); cfg_phase = DIV_W'(p);
        @(negedge refclk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int ch, input int v);
        int n = 0;
        while (!(st == M_RUN && mcnt(ch) == v) && n < 300) begin
            @(negedge refclk);
            n++;
        end
        if (!(st == M_RUN && mcnt(ch) == v)) chk("wait_cnt_timeout", 64'(n), 64'(0));
    endtask

    task automatic wait_locked();
        int n = 0;
        while (!locked && n < 400) begin
            @(negedge refclk);
            n++;
        end
        chk("relock", 64'(locked), 64'(1));
    endtask

    initial begin
        logic [20:0] v0;
        logic [11:0] v1o, v1s, v2o, v2s;
        logic [9:0] v3;
        logic [7:0] v8;
        logic [3:0] co, cs;
        logic [20:0] va [NUM_CH];
        int first, nz, run, minrun, n;
        logic prev, first_run;
        rst = 1'b1; lock_in = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_phase = '0;
        repeat (3) @(negedge refclk);
        chk("rst_outclk", 64'(outclk), 64'(0));
        chk("rst_strobe", 64'(strobe), 64'(0));
        chk("rst_locked", 64'(locked), 64'(0));
        chk("rst_ready", 64'(cfg_ready), 64'(1));
        rst = 1'b0;
        @(negedge refclk);
        send_cfg(1, 4, 3);
        send_cfg(2, 3, 0);
        lock_in = 1'b1;
        first = 0; v0 = '0; v1o = '0; v1s = '0; v2o = '0; v2s = '0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge refclk);
            if (k <= 21) v0 = {v0[19:0], outclk[0]};
            if (k <= 12) begin
                v1o = {v1o[10:0], outclk[1]}; v1s = {v1s[10:0], strobe[1]};
                v2o = {v2o[10:0], outclk[2]}; v2s = {v2s[10:0], strobe[2]};
            end
            if (locked && first == 0) first = k;
        end
        chk("lock_latency", 64'(first), 64'(257));
        chk("ch0_duty21", 64'(v0), 64'(21'h1FFC00));
        chk("ch1_outclk", 64'(v1o), 64'(12'hCCC));
        chk("ch1_strobe", 64'(v1s), 64'(12'h111));
        chk("ch2_outclk", 64'(v2o), 64'(12'hDB6));
        chk("ch2_strobe", 64'(v2s), 64'(12'h924));

        wait_cnt(0, 4);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = DIV_W'(8); cfg_phase = '0;
        nz = 0; minrun = 99; run = 0; prev = 1'b0; first_run = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge refclk);
            cfg_valid = 1'b0;
            if (!cfg_ready) nz++;
            if (k == 0) begin
                prev = outclk[0]; run = 1;
            end else if (outclk[0] == prev) run++;
            else begin
                if (!first_run && run < minrun) minrun = run;
                first_run = 1'b0; run = 1; prev = outclk[0];
            end
        end
        chk("update_ready_low", 64'(nz), 64'(16));
        chk("min_pulse_ge4", 64'(minrun >= 4), 64'(1));

        send_cfg(1, 0, 9);
        n = 0;
        while (!cfg_ready && n < 50) begin
            @(negedge refclk);
            n++;
        end
        co = '0; cs = '0;
        for (int k = 0; k < 4; k++) begin
            co = {co[2:0], outclk[1]}; cs = {cs[2:0], strobe[1]};
            @(negedge refclk);
        end
        chk("clamp_strobe", 64'(co ^ cs), 64'(4'hF));
        chk("clamp_outclk", 64'(co == 4'hA || co == 4'h5), 64'(1));

        send_cfg(NUM_CH, 3, 0);
        n = 1;
        while (!cfg_ready && n < 10) begin
            @(negedge refclk);
            n++;
        end
        chk("ignored_ready_lat", 64'(n), 64'(2));

        wait_cnt(3, 0);
        cfg_valid = 1'b1; cfg_ch = 3'd3; cfg_div = DIV_W'(10); cfg_phase = '0;
        @(negedge refclk);
        cfg_valid = 1'b0; sync = 1'b1;
        @(negedge refclk);
        sync = 1'b0;
        chk("sync_outclk", 64'(outclk), 64'(5'h1F));
        chk("sync_ready", 64'(cfg_ready), 64'(1));
        v3 = '0;
        for (int k = 0; k < 10; k++) begin
            v3 = {v3[8:0], outclk[3]};
            @(negedge refclk);
        end
        chk("sync_ch3_div10", 64'(v3), 64'(10'h3E0));

        wait_cnt(0, 0);
        cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = DIV_W'(6); cfg_phase = DIV_W'(2);
        @(negedge refclk);
        cfg_valid = 1'b0; lock_in = 1'b0;
        @(negedge refclk);
        chk("lockloss_outclk", 64'(outclk), 64'(0));
        chk("lockloss_strobe", 64'(strobe), 64'(0));
        chk("lockloss_locked", 64'(locked), 64'(0));
        chk("lockloss_ready", 64'(cfg_ready), 64'(1));
        lock_in = 1'b1;
        v8 = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge refclk);
            v8 = {v8[6:0], outclk[0]};
        end
        chk("relock_old_div8", 64'(v8), 64'(8'hF0));
        wait_locked();

        wait_cnt(2, 0);
        cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = DIV_W'(7); cfg_phase = DIV_W'(1);
        @(negedge refclk);
        cfg_valid = 1'b0; rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
        chk("midupd_rst_locked", 64'(locked), 64'(0));
        chk("midupd_rst_ready", 64'(cfg_ready), 64'(1));
        for (int i = 0; i < NUM_CH; i++) va[i] = '0;
        for (int k = 0; k < 21; k++) begin
            @(negedge refclk);
            for (int i = 0; i < NUM_CH; i++) va[i] = {va[i][19:0], outclk[i]};
        end
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("default_div_ch%0d", i), 64'(va[i]), 64'(21'h1FFC00));
        wait_locked();

        for (int k = 0; k < 3000; k++) begin
            cfg_valid = $urandom_range(0, 4) == 0;
            cfg_ch    = 3'($urandom_range(0, 7));
            cfg_div   = DIV_W'($urandom_range(0, 12));
            cfg_phase = DIV_W'($urandom_range(0, 14));
            sync      = $urandom_range(0, 39) == 0;
            lock_in   = $urandom_range(0, 999) != 0;
            rst       = $urandom_range(0, 1999) == 0;
            @(negedge refclk);
        end
        rst = 1'b0; cfg_valid = 1'b0; sync = 1'b0; lock_in = 1'b1;
        repeat (4) @(negedge refclk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
